xoodoo_perm_ctrl_sca: RTL
=========================

Name: xoodoo_perm_ctrl_SCA

Overview:
- Sequencer that runs a full masked Xoodoo permutation by iterating the single-round datapath (xoodoo_n_rounds_SCA) NROUNDS times.
- Registers the two 384-bit shares and the one-hot 13-bit round index j.
- Fetches one 384-bit fresh-randomness word per round through a valid/ready handshake, drives rdi_en, and hands results downstream with valid/ready.
- Sits between the Xoodyak cyclist/absorb logic (upstream) and the round datapath.

Parameters:
NROUNDS, 12, rounds per permutation; legal range 1..12.
ROUND_CYCLES, 2, clock cycles the round datapath needs from input to valid output (DOM register stage included); minimum 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start_valid  in  1  input shares valid
start_ready  out  1  controller can accept shares
in0  in  384  input share 0
in1  in  384  input share 1
rnd_valid  in  1  randomness word valid
rnd_ready  out  1  randomness word consumed this cycle
rnd_data  in  384  fresh randomness
out_valid  out  1  permuted shares valid
out_ready  in  1  downstream accepts
out0  out  384  result share 0
out1  out  384  result share 1
rd_state0  out  384  to round state_in0
rd_state1  out  384  to round state_in1
rd_rdi  out  384  to round rdi
rd_rdi_en  out  1  to round rdi_en
rd_j  out  13  to round j_in
rd_res0  in  384  from round state_out0
rd_res1  in  384  from round state_out1
rd_jnext  in  13  from round j_out

Behaviour:
- Registers: s0, s1 (384 each), j (13), cyc (ROUND_CYCLES counter), state. While rst=0: all cleared to 0, state=IDLE.
- Outputs after reset: start_ready=1, out_valid=0, rnd_ready=0, rd_rdi_en=0, out0=out1=0, rd_j=0.
- rd_state0=s0, rd_state1=s1, rd_j=j, rd_rdi=rnd_data; out0=s0, out1=s1 at all times.
- FSM:
  - IDLE: start_ready=1. On start_valid: s0<=in0, s1<=in1, j<=13'h0001, cyc<=0, go to ROUND.
  - ROUND, cyc==0: rnd_ready=rd_rdi_en=rnd_valid. If rnd_valid=0: stall, no counter change, rd_rdi_en=0. If rnd_valid=1: the word is consumed and cyc<=1, or the round completes immediately when ROUND_CYCLES==1.
  - ROUND, 0<cyc<ROUND_CYCLES-1: cyc++, rnd_ready=0, rd_rdi_en=0.
  - ROUND, round-completion cycle: s0<=rd_res0, s1<=rd_res1, j<=rd_jnext, cyc<=0. If rd_jnext[NROUNDS]==1, go to DONE; otherwise stay in ROUND.
  - DONE: out_valid=1. s0, s1 are held stable until out_ready=1, then go to IDLE and clear s0, s1, j to 0 so no share residue remains.
- Exactly one rnd_data word is consumed per round (NROUNDS per permutation). A word is never consumed in IDLE or DONE.
- rd_rdi_en is high only in the cycle of the rnd handshake.
- j sequence is 0001,0002,…,0800 for rounds 1..12. The final j register value is 1<<NROUNDS (13'h1000 for 12).
- Latency with rnd_valid tied high: out_valid rises NROUNDS*ROUND_CYCLES cycles after the start-accept edge (24 for defaults). Each rnd stall cycle adds exactly 1.
- start_valid in ROUND or DONE is ignored (start_ready=0); in0/in1 are not sampled.
- When out_ready and start_valid are both high in DONE: output completes; the new start is accepted in the following IDLE cycle.
- Async reset asserted mid-permutation: immediate return to IDLE, registers zeroed, no out_valid.
- No combinational path from out_ready to start_ready.

Test Plan:
- Reset then release, idle: start_ready=1, out_valid=0, rnd_ready=0, out0=out1=0.
- in0=in1=0, rnd_valid=1 with a random stream: out_valid at cycle 24 after accept. out0^out1 equals the golden Xoodoo[12] of the all-zero state. Exactly 12 rnd handshakes occur. rd_j steps 0001→0800.
- in0=random X, in1=X^P (unmasked P): out0^out1 == Xoodoo[12](P) for 100 random P and random rdi. Result is independent of the rdi values.
- rnd_valid low for 3 cycles at start of round 5: no state or j change during the stall. out_valid arrives at cycle 27.
- out_ready held low 10 cycles in DONE: out0/out1 stable, start_valid pulses ignored. On the out_ready handshake: IDLE, s0=s1=0, next start accepted.
- rst pulsed low at round 7: IDLE within the same cycle, all outputs at reset values. A fresh permutation afterwards is correct.

Source files
------------

// File: rtl/xoodoo_perm_ctrl_sca.sv
// xoodoo_perm_ctrl_sca: sequences NROUNDS passes of the masked Xoodoo round datapath,
// fetching one fresh-randomness word per round and handing both shares downstream.
module xoodoo_perm_ctrl_sca #(
  parameter int NROUNDS      = 12,
  parameter int ROUND_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [383:0] in0,
  input  logic [383:0] in1,
  input  logic         rnd_valid,
  output logic         rnd_ready,
  input  logic [383:0] rnd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [383:0] out0,
  output logic [383:0] out1,
  output logic [383:0] rd_state0,
  output logic [383:0] rd_state1,
  output logic [383:0] rd_rdi,
  output logic         rd_rdi_en,
  output logic [12:0]  rd_j,
  input  logic [383:0] rd_res0,
  input  logic [383:0] rd_res1,
  input  logic [12:0]  rd_jnext
);
  localparam int CW = ROUND_CYCLES > 1 ? $clog2(ROUND_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t         state_q, state_d;
  logic [383:0]   s0_q, s0_d, s1_q, s1_d;
  logic [12:0]    j_q, j_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic           fin;
  assign rd_state0 = s0_q;
  assign rd_state1 = s1_q;
  assign rd_j      = j_q;
  assign rd_rdi    = rnd_data;
  assign out0      = s0_q;
  assign out1      = s1_q;
  always_comb begin
    state_d     = state_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    j_d         = j_q;
    cyc_d       = cyc_q;
    start_ready = 1'b0;
    rnd_ready   = 1'b0;
    rd_rdi_en   = 1'b0;
    out_valid   = 1'b0;
    fin         = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          s0_d    = in0;
          s1_d    = in1;
          j_d     = 13'h0001;
          cyc_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (cyc_q == '0) begin
          rnd_ready = rnd_valid;
          rd_rdi_en = rnd_valid;
          if (rnd_valid) begin
            if (ROUND_CYCLES == 1) fin = 1'b1;
            else cyc_d = CW'(1);
          end
        end else if (cyc_q == CW'(ROUND_CYCLES - 1)) begin
          fin = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
        if (fin) begin
          s0_d    = rd_res0;
          s1_d    = rd_res1;
          j_d     = rd_jnext;
          cyc_d   = '0;
          state_d = rd_jnext[NROUNDS] ? DONE : ROUND;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Wipe both shares on hand-off so no masked residue lingers in IDLE.
        if (out_ready) begin
          s0_d    = '0;
          s1_d    = '0;
          j_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      j_q     <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      j_q     <= j_d;
      cyc_q   <= cyc_d;
    end
  end
endmodule
